// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream into 32-bit words,
// writes them to instruction memory and holds the core until a verified load.
module prog_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

    state_t              r_state;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last;
    logic [31:0]         r_wdata;
    logic [23:0]         r_asm;
    logic [7:0]          r_cnt_hi;
    logic [7:0]          r_sum;
    logic [1:0]          r_byte;
    logic                r_hold;
    logic                r_done;
    logic                r_err;

    logic                w_acc;
    logic [15:0]         w_n;
    logic [31:0]         w_word;

    assign w_acc  = rx_valid && r_rx_ready;
    assign w_n    = {r_cnt_hi, rx_data};
    assign w_word = {r_asm, rx_data};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_last     <= '0;
            r_wdata    <= '0;
            r_asm      <= '0;
            r_cnt_hi   <= '0;
            r_sum      <= '0;
            r_byte     <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Address advances on the edge that closes the write cycle.
            if (r_we) r_addr <= r_addr + ADDR_W'(1);
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_HDR_HI;
                        r_rx_ready <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_hold     <= 1'b1;
                        r_addr     <= '0;
                        r_byte     <= '0;
                        r_sum      <= '0;
                    end
                end
                S_HDR_HI: begin
                    if (w_acc) begin
                        r_cnt_hi <= rx_data;
                        r_state  <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_acc) begin
                        if (w_n == 16'd0 || {1'b0, w_n} > CAP) begin
                            r_state    <= S_ERROR;
                            r_rx_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_last  <= ADDR_W'(w_n - 16'd1);
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_asm  <= {r_asm[15:0], rx_data};
                        r_sum  <= r_sum + rx_data;
                        r_byte <= r_byte + 2'd1;
                        if (r_byte == 2'd3) begin
                            r_wdata <= w_word;
                            r_we    <= 1'b1;
                            // r_addr already holds this word's index: the
                            // previous increment landed at least 3 cycles ago.
                            if (r_addr == r_last) r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_acc) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_sum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b0;
                    r_hold     <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_hold  = r_hold;
    assign done       = r_done;
    assign error      = r_err;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the instruction memory and the PC of the single-cycle MIPS core. It receives a framed byte stream (header, big-endian instruction words, checksum) over a valid/ready handshake. It writes each assembled 32-bit instruction into instruction memory, word by word. While loading, it holds the core in reset through `core_hold`, and releases the core only after a verified load.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2**ADDR_W words.
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: level sampled each cycle; begins a load when in IDLE, DONE or ERROR.
- `rx_valid`  in  1: a byte is offered on `rx_data`.
- `rx_data`  in  8: stream byte.
- `rx_ready`  out  1: loader accepts a byte this cycle. Transfer occurs when `rx_valid && rx_ready` at a rising edge.
- `imem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W: word index of the current or next write.
- `imem_wdata`  out  32: assembled instruction word.
- `core_hold`  out  1: holds the core (PC and regfile) in reset while high.
- `done`  out  1: load completed and checksum matched.
- `error`  out  1: load aborted (bad length or checksum mismatch).

## Operation
- **Frame format:** `CNT_HI`, `CNT_LO`, then N×4 data bytes, then `CSUM`.
  - N = {`CNT_HI`,`CNT_LO`}.
  - Each word is sent MSB first: byte0 → [31:24] … byte3 → [7:0].
  - `CSUM` = 8-bit wrap-around sum of all data bytes. Header bytes are excluded.
- **States:** IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR.
- **IDLE / DONE / ERROR:**
  - `rx_ready`=0.
  - `start`=1 → HDR_HI. On that transition: clear `done` and `error`, set `core_hold`=1, and zero the word index, byte counter and running sum.
- **HDR_HI:** `rx_ready`=1. On accept, latch the high byte → HDR_LO.
- **HDR_LO:** `rx_ready`=1. On accept, form N.
  - N==0 or N>2**ADDR_W → ERROR.
  - Otherwise → DATA.
- **DATA:**
  - `rx_ready`=1. Each accepted byte shifts into a 32-bit assembly register and is added to the sum (mod 256).
  - On acceptance of the 4th byte of a word, register `imem_wdata` = assembled word and assert `imem_we` for the next cycle only.
  - After the edge that ends that write cycle, `imem_addr` increments by 1.
  - After the 4th byte of word N-1 → CSUM.
- **CSUM:** `rx_ready`=1. On accept, compare with the running sum.
  - Equal → DONE.
  - Not equal → ERROR.
- **Output by state:**
  - DONE: `done`=1, `core_hold`=0.
  - ERROR: `error`=1, `core_hold`=1.
  - All other states: `core_hold`=1.
- `start` is ignored in HDR_HI, HDR_LO, DATA and CSUM.
- Words already written before an error are not rolled back.
- **Reset (Reset=0), at any time including mid-load:**
  - Immediate return to IDLE.
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=1, `done`=0, `error`=0.
  - Byte counter, sum and N are cleared.
- **Wrap:** `imem_addr` never exceeds 2**ADDR_W-1. The length check guarantees this, so the increment after the final word at max capacity may wrap to 0 harmlessly.

## Timing
- One byte per cycle maximum. `rx_ready` is registered on state only; it does not depend on `rx_valid`.
- `imem_we` is high exactly one cycle, the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` are stable during that cycle.
- A new byte may be accepted in the same cycle that `imem_we` is high. There are no bubbles.
- `done`/`error` assert, and `core_hold` updates, one cycle after the accepting edge of `CSUM` (or of `CNT_LO` for a length error).
- Minimum load latency: 3 + 4N accepting edges + 1 cycle to `done`.
- Gaps in `rx_valid` stall the FSM with all state held. `imem_we` is never re-asserted while stalled.

## Test plan
- **Reset values:** hold Reset=0 for 3 cycles, then release.
  - → `core_hold`=1, `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `done`=0, `error`=0.
- **Good load, back-to-back:** start, then bytes 00 02 20 08 00 05 20 09 00 07 5D.
  - → `imem_we` pulses with (addr 0, 0x20080005) and (addr 1, 0x20090007).
  - → `done`=1 and `core_hold`=0 one cycle after 5D.
- **Bad checksum:** same frame with final byte 5E.
  - → both writes still occur.
  - → `error`=1, `core_hold`=1, `done`=0.
  - → a following start plus the good frame gives `done`=1, with writes starting at addr 0.
- **Length bounds (ADDR_W=8):**
  - Header 00 00 → `error`=1 after `CNT_LO`, no `imem_we`.
  - Header 01 01 → `error`=1.
  - Header 01 00 followed by 1024 bytes plus correct checksum → 256 writes to addr 0..255, `done`=1.
- **Stalls and ignored start:** good 2-word frame with 1–3 idle `rx_valid` cycles between bytes, and `start` pulsed during DATA.
  - → identical writes and `done`.
  - → `imem_we` is never high for more than one cycle.
- **Reset mid-load:** assert Reset asynchronously after the 6th data byte.
  - → outputs return to reset values in the same cycle.
  - → after release, start plus the good frame → writes at addr 0,1 and `done`=1.
